// File: rtl/id_stage.sv
// id_stage: registered RV32/RV64 instruction decoder between IF and EX.
// A flagged bundle (illegal/ebreak/ecall) parks the stage in HALT until flush.
module id_stage #(
    parameter int XLEN  = 32,
    parameter int NREG  = 32,
    parameter int HAS_M = 0,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [XLEN-1:0]  in_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_pc,
    output logic [4:0]       out_rs1,
    output logic [4:0]       out_rs2,
    output logic [4:0]       out_rd,
    output logic [XLEN-1:0]  out_imm,
    output logic [4:0]       out_alu_op,
    output logic             out_reg_write,
    output logic             out_mem_read,
    output logic             out_mem_write,
    output logic [1:0]       out_mem_len,
    output logic             out_mem_unsigned,
    output logic             out_word,
    output logic             out_branch,
    output logic             out_jal,
    output logic             out_jalr,
    output logic             out_lui,
    output logic             out_auipc,
    output logic             out_ebreak,
    output logic             out_ecall,
    output logic             out_illegal,
    output logic [CNT_W-1:0] dec_count
);
    localparam logic [0:0] RUN  = 1'b0;
    localparam logic [0:0] HALT = 1'b1;
    localparam bit RV64 = (XLEN == 64);
    localparam logic [4:0] ADD = 5'd0, SUB = 5'd1, SRL = 5'd6, SRA = 5'd7, SLT = 5'd8, SLTU = 5'd9;
    // funct3 -> alu_op for the register/immediate integer ops (index 0 = ADD ... 7 = AND)
    localparam logic [7:0][4:0] F3_ALU = {5'd2, 5'd3, 5'd6, 5'd4, 5'd9, 5'd8, 5'd5, 5'd0};

    logic [0:0] state;
    logic [6:0] opc, f7;
    logic [2:0] f3;
    logic [4:0] rs1_f, rs2_f, rd_f, m_alu;
    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic sh_zero, sh_sra, accept, ill, exc;
    logic u1, u2, ud, d_ill, d_rw, d_mr, d_mw, d_uns, d_word, d_br, d_jal, d_jalr, d_lui, d_auipc, d_eb, d_ec;
    logic [4:0] d_alu;
    logic [1:0] d_len;
    logic [XLEN-1:0] d_imm;

    assign opc   = in_instr[6:0];
    assign f3    = in_instr[14:12];
    assign f7    = in_instr[31:25];
    assign rs1_f = in_instr[19:15];
    assign rs2_f = in_instr[24:20];
    assign rd_f  = in_instr[11:7];
    assign m_alu = 5'd10 + {2'b00, f3};
    assign imm_i = XLEN'($signed(in_instr[31:20]));
    assign imm_s = XLEN'($signed({in_instr[31:25], in_instr[11:7]}));
    assign imm_b = XLEN'($signed({in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0}));
    assign imm_u = XLEN'($signed({in_instr[31:12], 12'h000}));
    assign imm_j = XLEN'($signed({in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0}));
    // RV64 shift immediates borrow instr[25] as shamt[5]
    assign sh_zero = RV64 ? (in_instr[31:26] == 6'b000000) : (f7 == 7'b0000000);
    assign sh_sra  = RV64 ? (in_instr[31:26] == 6'b010000) : (f7 == 7'b0100000);

    always_comb begin
        {u1, u2, ud, d_ill, d_rw, d_mr, d_mw, d_uns, d_word} = '0;
        {d_br, d_jal, d_jalr, d_lui, d_auipc, d_eb, d_ec} = '0;
        d_alu = ADD;
        d_len = 2'd0;
        d_imm = '0;
        case (opc)
            7'b0110111: begin d_lui = 1'b1; d_rw = 1'b1; ud = 1'b1; d_imm = imm_u; end
            7'b0010111: begin d_auipc = 1'b1; d_rw = 1'b1; ud = 1'b1; d_imm = imm_u; end
            7'b1101111: begin d_jal = 1'b1; d_rw = 1'b1; ud = 1'b1; d_imm = imm_j; end
            7'b1100111: begin
                d_jalr = 1'b1; d_rw = 1'b1; u1 = 1'b1; ud = 1'b1; d_imm = imm_i;
                d_ill = f3 != 3'b000;
            end
            7'b1100011: begin
                d_br = 1'b1; u1 = 1'b1; u2 = 1'b1; d_imm = imm_b;
                d_alu = f3[2] ? (f3[1] ? SLTU : SLT) : SUB;
                d_ill = f3[2:1] == 2'b01;
            end
            7'b0000011: begin
                d_mr = 1'b1; d_rw = 1'b1; u1 = 1'b1; ud = 1'b1; d_imm = imm_i;
                d_len = f3[1:0];
                d_uns = f3[2];
                d_ill = f3 == 3'b111 || (!RV64 && (f3 == 3'b011 || f3 == 3'b110));
            end
            7'b0100011: begin
                d_mw = 1'b1; u1 = 1'b1; u2 = 1'b1; d_imm = imm_s;
                d_len = f3[1:0];
                d_ill = f3[2] || (!RV64 && f3 == 3'b011);
            end
            7'b0010011: begin
                d_rw = 1'b1; u1 = 1'b1; ud = 1'b1; d_imm = imm_i;
                d_alu = F3_ALU[f3];
                if (f3 == 3'b001) d_ill = !sh_zero;
                if (f3 == 3'b101) begin
                    d_ill = !(sh_zero || sh_sra);
                    d_alu = sh_sra ? SRA : SRL;
                end
            end
            7'b0011011: begin
                d_rw = 1'b1; u1 = 1'b1; ud = 1'b1; d_imm = imm_i; d_word = 1'b1;
                d_alu = F3_ALU[f3];
                d_ill = !RV64 || !(f3 == 3'b000 || (f3 == 3'b001 && f7 == 7'h00) ||
                                   (f3 == 3'b101 && (f7 == 7'h00 || f7 == 7'h20)));
                if (f3 == 3'b101) d_alu = f7[5] ? SRA : SRL;
            end
            7'b0110011: begin
                d_rw = 1'b1; u1 = 1'b1; u2 = 1'b1; ud = 1'b1;
                d_alu = f7 == 7'h20 ? (f3 == 3'b000 ? SUB : SRA) : f7 == 7'h01 ? m_alu : F3_ALU[f3];
                d_ill = !(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101)) ||
                          (f7 == 7'h01 && HAS_M != 0));
            end
            7'b0111011: begin
                d_rw = 1'b1; u1 = 1'b1; u2 = 1'b1; ud = 1'b1; d_word = 1'b1;
                d_alu = f7 == 7'h20 ? (f3 == 3'b000 ? SUB : SRA) : f7 == 7'h01 ? m_alu : F3_ALU[f3];
                d_ill = !RV64 || !((f7 == 7'h00 && (f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b101)) ||
                                   (f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101)) ||
                                   (f7 == 7'h01 && HAS_M != 0 && (f3 == 3'b000 || f3[2])));
            end
            7'b1110011: begin
                d_eb  = in_instr == 32'h0010_0073;
                d_ec  = in_instr == 32'h0000_0073;
                d_ill = !(d_eb || d_ec);
            end
            default: d_ill = 1'b1;
        endcase
    end

    assign ill = d_ill || (u1 && 32'(rs1_f) >= NREG) || (u2 && 32'(rs2_f) >= NREG) ||
                 (ud && 32'(rd_f) >= NREG);
    assign exc      = ill || d_eb || d_ec;
    assign in_ready = (state == RUN) && !flush && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
            out_valid <= 1'b0;
            dec_count <= '0;
            out_pc <= '0;
            out_imm <= '0;
            {out_rs1, out_rs2, out_rd, out_alu_op, out_mem_len} <= '0;
            {out_reg_write, out_mem_read, out_mem_write, out_mem_unsigned, out_word} <= '0;
            {out_branch, out_jal, out_jalr, out_lui, out_auipc, out_ebreak, out_ecall, out_illegal} <= '0;
        end else begin
            if (out_valid && out_ready && !flush) dec_count <= dec_count + 1'b1;
            if (flush) begin
                out_valid <= 1'b0;
                state <= RUN;
            end else if (accept) begin
                out_valid <= 1'b1;
                if (exc) state <= HALT;
                out_pc <= in_pc;
                out_rs1 <= u1 ? rs1_f : 5'd0;
                out_rs2 <= u2 ? rs2_f : 5'd0;
                out_rd <= ud ? rd_f : 5'd0;
                out_imm <= d_imm;
                out_alu_op <= ill ? ADD : d_alu;
                out_reg_write <= d_rw && !ill;
                out_mem_read <= d_mr && !ill;
                out_mem_write <= d_mw && !ill;
                out_mem_len <= d_len;
                out_mem_unsigned <= d_uns;
                out_word <= d_word && !ill;
                out_branch <= d_br && !ill;
                out_jal <= d_jal && !ill;
                out_jalr <= d_jalr && !ill;
                out_lui <= d_lui && !ill;
                out_auipc <= d_auipc && !ill;
                out_ebreak <= d_eb && !ill;
                out_ecall <= d_ec && !ill;
                out_illegal <= ill;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_id_stage.sv
// tb_id_stage: directed checks of id_stage; second instance runs HAS_M=1, NREG=16.
module tb_id_stage;
    logic clk = 1'b0, rst_n, flush, in_valid, out_ready;
    logic [31:0] in_instr, in_pc;
    int n_chk = 0, n_fail = 0;

    logic in_ready, out_valid, out_reg_write, out_mem_read, out_mem_write, out_mem_unsigned, out_word;
    logic out_branch, out_jal, out_jalr, out_lui, out_auipc, out_ebreak, out_ecall, out_illegal;
    logic [31:0] out_pc, out_imm, dec_count;
    logic [4:0] out_rs1, out_rs2, out_rd, out_alu_op;
    logic [1:0] out_mem_len;

    logic m_in_ready, m_out_valid, m_out_reg_write, m_out_mem_read, m_out_mem_write, m_out_mem_unsigned, m_out_word;
    logic m_out_branch, m_out_jal, m_out_jalr, m_out_lui, m_out_auipc, m_out_ebreak, m_out_ecall, m_out_illegal;
    logic [31:0] m_out_pc, m_out_imm, m_dec_count;
    logic [4:0] m_out_rs1, m_out_rs2, m_out_rd, m_out_alu_op;
    logic [1:0] m_out_mem_len;

    logic [11:0] flags;
    assign flags = {out_mem_read, out_mem_write, out_mem_len, out_mem_unsigned, out_branch,
                    out_jal, out_jalr, out_lui, out_auipc, out_ebreak, out_ecall};

    always #5 clk = ~clk;

    id_stage dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd), .out_imm(out_imm),
        .out_alu_op(out_alu_op), .out_reg_write(out_reg_write), .out_mem_read(out_mem_read),
        .out_mem_write(out_mem_write), .out_mem_len(out_mem_len), .out_mem_unsigned(out_mem_unsigned),
        .out_word(out_word), .out_branch(out_branch), .out_jal(out_jal), .out_jalr(out_jalr),
        .out_lui(out_lui), .out_auipc(out_auipc), .out_ebreak(out_ebreak), .out_ecall(out_ecall),
        .out_illegal(out_illegal), .dec_count(dec_count)
    );

    id_stage #(.HAS_M(1), .NREG(16)) dut_m (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(m_in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .out_valid(m_out_valid), .out_ready(out_ready),
        .out_pc(m_out_pc), .out_rs1(m_out_rs1), .out_rs2(m_out_rs2), .out_rd(m_out_rd), .out_imm(m_out_imm),
        .out_alu_op(m_out_alu_op), .out_reg_write(m_out_reg_write), .out_mem_read(m_out_mem_read),
        .out_mem_write(m_out_mem_write), .out_mem_len(m_out_mem_len), .out_mem_unsigned(m_out_mem_unsigned),
        .out_word(m_out_word), .out_branch(m_out_branch), .out_jal(m_out_jal), .out_jalr(m_out_jalr),
        .out_lui(m_out_lui), .out_auipc(m_out_auipc), .out_ebreak(m_out_ebreak), .out_ecall(m_out_ecall),
        .out_illegal(m_out_illegal), .dec_count(m_dec_count)
    );

    typedef struct packed {
        logic [31:0] ins;
        logic        ill;
        logic [4:0]  alu;
        logic        rw;
        logic [31:0] imm;
        logic [11:0] fl;
    } vec_t;

    // flags: {mem_read, mem_write, mem_len[1:0], mem_unsigned, branch, jal, jalr, lui, auipc, ebreak, ecall}
    vec_t vecs [18] = '{
        '{32'hFFF0_0093, 1'b0, 5'd0, 1'b1, 32'hFFFF_FFFF, 12'h000},
        '{32'h0020_8463, 1'b0, 5'd1, 1'b0, 32'h0000_0008, 12'h040},
        '{32'hFFF0_C283, 1'b0, 5'd0, 1'b1, 32'hFFFF_FFFF, 12'h880},
        '{32'h0020_A223, 1'b0, 5'd0, 1'b0, 32'h0000_0004, 12'h600},
        '{32'h0000_B283, 1'b1, 5'd0, 1'b0, 32'h0000_0000, 12'h000},
        '{32'h8000_00B7, 1'b0, 5'd0, 1'b1, 32'h8000_0000, 12'h008},
        '{32'h0010_00EF, 1'b0, 5'd0, 1'b1, 32'h0000_0800, 12'h020},
        '{32'h0000_80E7, 1'b0, 5'd0, 1'b1, 32'h0000_0000, 12'h010},
        '{32'h0000_90E7, 1'b1, 5'd0, 1'b0, 32'h0000_0000, 12'h000},
        '{32'h4030_D093, 1'b0, 5'd7, 1'b1, 32'h0000_0403, 12'h000},
        '{32'h4030_9093, 1'b1, 5'd0, 1'b0, 32'h0000_0000, 12'h000},
        '{32'h0020_A463, 1'b1, 5'd0, 1'b0, 32'h0000_0000, 12'h000},
        '{32'h0000_0073, 1'b0, 5'd0, 1'b0, 32'h0000_0000, 12'h001},
        '{32'h0010_0073, 1'b0, 5'd0, 1'b0, 32'h0000_0000, 12'h002},
        '{32'h0020_E463, 1'b0, 5'd9, 1'b0, 32'h0000_0008, 12'h040},
        '{32'h0000_1097, 1'b0, 5'd0, 1'b1, 32'h0000_1000, 12'h004},
        '{32'h0000_0012, 1'b1, 5'd0, 1'b0, 32'h0000_0000, 12'h000},
        '{32'h0020_C1B3, 1'b0, 5'd4, 1'b1, 32'h0000_0000, 12'h000}
    };

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic issue(input logic [31:0] ins);
        @(negedge clk);
        in_valid = 1'b1;
        in_instr = ins;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic flush_pulse();
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0; out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_valid", out_valid, 0);
        check("rst_count", dec_count, 0);
        check("rst_imm", out_imm, 0);
        check("rst_rd", out_rd, 0);
        check("rst_in_ready", in_ready, 1);
        rst_n = 1'b1;
        // basic decode
        @(negedge clk);
        in_valid = 1'b1; in_instr = 32'hFFF0_0093; in_pc = 32'h100; out_ready = 1'b1;
        #1 check("basic_in_ready", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        check("basic_valid", out_valid, 1);
        check("basic_rd", out_rd, 1);
        check("basic_imm", out_imm, 32'hFFFF_FFFF);
        check("basic_alu", out_alu_op, 0);
        check("basic_rw", out_reg_write, 1);
        check("basic_pc", out_pc, 32'h100);
        check("basic_count0", dec_count, 0);
        @(negedge clk);
        check("basic_count1", dec_count, 1);
        check("basic_drain", out_valid, 0);
        check("basic_m_count", m_dec_count, 1);
        // backpressure
        out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h0020_8133; in_pc = 32'h200;
        @(negedge clk);
        check("bp_first_valid", out_valid, 1);
        check("bp_first_rd", out_rd, 2);
        in_instr = 32'h4020_81B3; in_pc = 32'h204;
        #1 check("bp_in_ready", in_ready, 0);
        @(negedge clk);
        check("bp_hold_valid", out_valid, 1);
        check("bp_hold_pc", out_pc, 32'h200);
        check("bp_hold_rd", out_rd, 2);
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check("bp_second_pc", out_pc, 32'h204);
        check("bp_second_alu", out_alu_op, 1);
        check("bp_second_rd", out_rd, 3);
        check("bp_count2", dec_count, 2);
        @(negedge clk);
        check("bp_drain", out_valid, 0);
        check("bp_count3", dec_count, 3);
        // ebreak halt
        in_valid = 1'b1; in_instr = 32'h0010_0073; in_pc = 32'h300;
        @(negedge clk);
        in_instr = 32'hFFF0_0093;
        check("eb_flag", out_ebreak, 1);
        check("eb_valid", out_valid, 1);
        check("eb_illegal", out_illegal, 0);
        #1 check("eb_in_ready", in_ready, 0);
        @(negedge clk);
        check("eb_drain", out_valid, 0);
        check("eb_count", dec_count, 4);
        check("eb_halt_ready", in_ready, 0);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        #1 check("eb_resume_ready", in_ready, 1);
        // all-zero word
        issue(32'h0000_0000);
        check("zero_illegal", out_illegal, 1);
        check("zero_rw", out_reg_write, 0);
        check("zero_valid", out_valid, 1);
        @(negedge clk);
        check("zero_count", dec_count, 5);
        flush_pulse();
        // MUL with and without M
        issue(32'h0220_81B3);
        check("mul_nom_illegal", out_illegal, 1);
        check("mul_m_illegal", m_out_illegal, 0);
        check("mul_m_alu", m_out_alu_op, 10);
        check("mul_m_rd", m_out_rd, 3);
        @(negedge clk);
        flush_pulse();
        // x16 is out of range only for the RV32E instance
        issue(32'h0100_0833);
        check("x16_rv32i_illegal", out_illegal, 0);
        check("x16_rv32i_rd", out_rd, 16);
        check("x16_rv32e_illegal", m_out_illegal, 1);
        @(negedge clk);
        flush_pulse();
        for (int i = 0; i < 18; i++) begin
            issue(vecs[i].ins);
            check($sformatf("v%0d_illegal", i), out_illegal, vecs[i].ill);
            check($sformatf("v%0d_alu", i), out_alu_op, vecs[i].alu);
            check($sformatf("v%0d_rw", i), out_reg_write, vecs[i].rw);
            if (!vecs[i].ill) begin
                check($sformatf("v%0d_imm", i), out_imm, vecs[i].imm);
                check($sformatf("v%0d_flags", i), flags, vecs[i].fl);
            end
            @(negedge clk);
            flush_pulse();
        end
        // flush kills a held bundle without counting it
        out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'hFFF0_0093;
        @(negedge clk);
        in_valid = 1'b0;
        check("fk_held", out_valid, 1);
        flush_pulse();
        check("fk_valid", out_valid, 0);
        check("fk_count", dec_count, 7 + 18);
        // flush beats a simultaneous handshake
        out_ready = 1'b1; in_valid = 1'b1; flush = 1'b1;
        #1 check("fh_in_ready", in_ready, 0);
        @(negedge clk);
        check("fh_valid", out_valid, 0);
        flush = 1'b0; in_valid = 1'b0;
        // asynchronous reset while a bundle is held
        out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'hFFF0_0093;
        @(negedge clk);
        in_valid = 1'b0;
        check("ar_held", out_valid, 1);
        #2 rst_n = 1'b0;
        #1 check("ar_valid", out_valid, 0);
        check("ar_count", dec_count, 0);
        @(negedge clk);
        rst_n = 1'b1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
